// File: rtl/bus6502_pkg.sv
// bus6502_pkg: shared FSM states, FIFO entry type and constants for the 6502 write bridge
package bus6502_pkg;
   typedef enum logic [1:0] {C_IDLE, C_ACTIVE, C_WAIT} cap_state_e;
   typedef enum logic {D_IDLE, D_HOLD} drn_state_e;
   typedef struct packed {
      logic [14:0] addr;
      logic [7:0]  data;
   } wr_entry_t;
   localparam logic [7:0] BANK_DEFAULT = 8'd1;
   localparam int PROTECT_BIT = 14;
endpackage

// File: rtl/bus6502_wr_fifo.sv
// bus6502_wr_fifo: synchronous FIFO; a push into a full FIFO is accepted only alongside a pop
module bus6502_wr_fifo #(
   parameter int DEPTH = 4,
   parameter int W = 23,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [W-1:0]  wdata_i,
   output logic          accept_o,
   input  logic          pop_i,
   output logic [W-1:0]  rdata_o,
   output logic          empty_o,
   output logic [AW:0]   level_o
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q;
   logic          do_pop, full;
   assign do_pop   = pop_i && !empty_o;
   assign full     = cnt_q == (AW+1)'(DEPTH);
   assign accept_o = push_i && (!full || do_pop);
   assign empty_o  = cnt_q == '0;
   assign level_o  = cnt_q;
   assign rdata_o  = mem_q[rd_ptr_q];
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (accept_o) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(accept_o) - (AW+1)'(do_pop);
      end
   always_ff @(posedge clk)
      if (accept_o) mem_q[wr_ptr_q] <= wdata_i;
endmodule

// File: rtl/bus6502_wr.sv
// bus6502_wr: posts 6502 write cycles into a FIFO and drains them to SDRAM as byte writes.
// BUS6502_WR_PROTECT_EN discards writes to the $C000-$FFFF program region and adds prot_hit.
module bus6502_wr
   import bus6502_pkg::*;
#(
   parameter int         FIFO_DEPTH  = 4,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] BANK        = BANK_DEFAULT,
   localparam int        LW          = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    c6502_data,
   input  logic [14:0]   c6502_addr,
   input  logic          c6502_rw,
   input  logic          c6502_cs,
   output logic [22:0]   ram_addr,
   output logic [7:0]    data_in,
   output logic          ram_rw,
   output logic          in_valid,
   input  logic          busy,
   input  logic          grant,
   output logic          wr_pending,
   output logic [LW-1:0] fifo_level,
   output logic          ovf,
`ifdef BUS6502_WR_PROTECT_EN
   output logic          prot_hit,
`endif
   input  logic          clr_ovf
);
   localparam logic [24:0] SYNC_IDLE = {2'b11, 23'b0};
   logic [24:0] sync_q [SYNC_STAGES];
   logic        cs_s, rw_s;
   wr_entry_t   s_entry, hold_q, head;
   cap_state_e  cap_q;
   drn_state_e  drn_q;
   logic        push_req, blocked, push, accept, issue, empty;
   // All bus signals share one sync chain so each sample is coherent
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_IDLE;
      end else begin
         sync_q[0] <= {c6502_cs, c6502_rw, c6502_addr, c6502_data};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   assign {cs_s, rw_s, s_entry} = sync_q[SYNC_STAGES-1];
   assign push_req = cap_q == C_ACTIVE && cs_s;
`ifdef BUS6502_WR_PROTECT_EN
   assign blocked = hold_q.addr[PROTECT_BIT];
`else
   assign blocked = 1'b0;
`endif
   assign push = push_req && !blocked;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         cap_q  <= C_IDLE;
         hold_q <= '0;
      end else begin
         case (cap_q)
            C_IDLE: if (!cs_s && !rw_s) begin
               cap_q  <= C_ACTIVE;
               hold_q <= s_entry;
            end
            C_ACTIVE:
               if (cs_s) cap_q <= C_IDLE;
               else if (rw_s) cap_q <= C_WAIT;
               else hold_q <= s_entry;
            default: if (cs_s) cap_q <= C_IDLE;
         endcase
      end
   bus6502_wr_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(wr_entry_t))) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_i   (push),
      .wdata_i  (hold_q),
      .accept_o (accept),
      .pop_i    (issue),
      .rdata_o  (head),
      .empty_o  (empty),
      .level_o  (fifo_level)
   );
   assign wr_pending = !empty;
   always_ff @(posedge clk or negedge rst)
      if (!rst) ovf <= 1'b0;
      else if (push && !accept) ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
`ifdef BUS6502_WR_PROTECT_EN
   always_ff @(posedge clk or negedge rst)
      if (!rst) prot_hit <= 1'b0;
      else if (push_req && blocked) prot_hit <= 1'b1;
      else if (clr_ovf) prot_hit <= 1'b0;
`endif
   // D_HOLD gives the controller one cycle to raise busy before the next issue
   assign issue = drn_q == D_IDLE && !empty && grant && !busy;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         drn_q    <= D_IDLE;
         ram_addr <= '0;
         data_in  <= '0;
         ram_rw   <= 1'b0;
         in_valid <= 1'b0;
      end else begin
         in_valid <= issue;
         drn_q    <= issue ? D_HOLD : D_IDLE;
         if (issue) begin
            ram_addr <= {BANK, head.addr};
            data_in  <= head.data;
            ram_rw   <= 1'b1;
         end
      end
endmodule

// File: tb/tb_bus6502_wr.sv
// tb_bus6502_wr: scoreboard bench for bus6502_wr; expected SDRAM writes are queued at stimulus time
module tb_bus6502_wr;
   import bus6502_pkg::*;
   localparam int SYNC = 2;
   logic        clk = 0, rst = 0;
   logic [7:0]  data = 0;
   logic [14:0] addr = 0;
   logic        rw = 1, cs = 1, busy = 0, grant = 0, clr_ovf = 0;
   logic [22:0] ram_addr;
   logic [7:0]  data_in;
   logic        ram_rw, in_valid, wr_pending, ovf;
   logic [2:0]  fifo_level;
`ifdef BUS6502_WR_PROTECT_EN
   logic        prot_hit;
`endif
   bus6502_wr dut (
      .clk        (clk),
      .rst        (rst),
      .c6502_data (data),
      .c6502_addr (addr),
      .c6502_rw   (rw),
      .c6502_cs   (cs),
      .ram_addr   (ram_addr),
      .data_in    (data_in),
      .ram_rw     (ram_rw),
      .in_valid   (in_valid),
      .busy       (busy),
      .grant      (grant),
      .wr_pending (wr_pending),
      .fifo_level (fifo_level),
      .ovf        (ovf),
`ifdef BUS6502_WR_PROTECT_EN
      .prot_hit   (prot_hit),
`endif
      .clr_ovf    (clr_ovf)
   );
   always #5 clk = ~clk;
   int n_cmp = 0, n_err = 0, cyc = 0, n_pulse = 0;
   logic [30:0] exp_q [$];
   int pulse_t [$];
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask
   always @(negedge clk)
      if (rst && in_valid) begin
         n_pulse++;
         pulse_t.push_back(cyc);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: got %h expected none", {ram_addr, data_in});
         end else check("sdram_write", {ram_rw, ram_addr, data_in}, {1'b1, exp_q.pop_front()});
      end
   task automatic wr(input logic [14:0] a, input logic [7:0] d, input bit issued);
      @(posedge clk); #2;
      cs = 0; rw = 0; addr = a; data = d;
      if (issued) exp_q.push_back({BANK_DEFAULT, a, d});
      repeat (3) @(posedge clk);
      #2 cs = 1;
   endtask
   task automatic wait_drain();
      for (int k = 0; k < 80 && exp_q.size() != 0; k++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1 check("drain_empty", exp_q.size(), 0);
   endtask
   task automatic pulse_clr();
      @(posedge clk); #2 clr_ovf = 1;
      @(posedge clk); #2 clr_ovf = 0;
      #1;
   endtask
   initial begin
      int got, base, bn;
      #1;
      check("rst_in_valid", in_valid, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_data_in", data_in, 0);
      check("rst_ram_rw", ram_rw, 0);
      check("rst_level", {wr_pending, fifo_level, ovf}, 0);
      repeat (3) @(negedge clk);
      rst = 1;
      // single write, latency bound
      grant = 1;
      wr(15'h0123, 8'h5A, 1);
      got = 0;
      for (int k = 1; k <= SYNC + 3; k++) begin
         @(negedge clk);
         if (in_valid) begin got = k; break; end
      end
      check("t1_latency_ok", got != 0, 1);
      wait_drain();
      // fill with grant low, then overflow
      grant = 0;
      bn = n_pulse;
      for (int i = 0; i < 4; i++) wr(15'h0010 + 15'(i), 8'hA0 + 8'(i), 1);
      repeat (5) @(posedge clk);
      #1 check("t2_level_full", fifo_level, 4);
      check("t2_pending", wr_pending, 1);
      check("t2_no_issue", n_pulse, bn);
      check("t2_ovf_clear", ovf, 0);
      wr(15'h0014, 8'hEE, 0);
      repeat (5) @(posedge clk);
      #1 check("t2_ovf_set", ovf, 1);
      check("t2_level_kept", fifo_level, 4);
      pulse_clr();
      check("t2_ovf_cleared", ovf, 0);
      base = pulse_t.size();
      grant = 1;
      wait_drain();
      check("t2_pulses", n_pulse, bn + 4);
      if (pulse_t.size() >= base + 4)
         for (int i = 1; i < 4; i++) check("t2_gap", pulse_t[base+i] - pulse_t[base+i-1], 2);
      // busy stalls the drain
      busy = 1;
      bn = n_pulse;
      wr(15'h0200, 8'h11, 1);
      wr(15'h0201, 8'h22, 1);
      repeat (20) @(posedge clk);
      #1 check("t3_stalled", n_pulse, bn);
      check("t3_level", fifo_level, 2);
      busy = 0;
      wait_drain();
      check("t3_pulses", n_pulse, bn + 2);
      // read cycle is ignored
      @(posedge clk); #2;
      cs = 0; rw = 1; addr = 15'h7FFC; data = 8'h99;
      repeat (3) @(posedge clk);
      #2 cs = 1;
      repeat (6) @(posedge clk);
      #1 check("t4_no_push", {wr_pending, fifo_level}, 0);
      // async reset mid-drain
      grant = 0;
      for (int i = 0; i < 3; i++) wr(15'h0300 + 15'(i), 8'h70 + 8'(i), 1);
      repeat (5) @(posedge clk);
      #1 check("t5_level", fifo_level, 3);
      grant = 1;
      got = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (in_valid) begin got = 1; break; end
      end
      check("t5_issue_seen", got, 1);
      @(negedge clk); #1 rst = 0;
      #1 check("t5_rst_in_valid", in_valid, 0);
      check("t5_rst_level", {wr_pending, fifo_level}, 0);
      check("t5_rst_ram_rw", ram_rw, 0);
      exp_q.delete();
      bn = n_pulse;
      @(negedge clk) rst = 1;
      repeat (10) @(posedge clk);
      #1 check("t5_no_more", n_pulse, bn);
`ifdef BUS6502_WR_PROTECT_EN
      wr(15'h4000, 8'h33, 0);
      repeat (6) @(posedge clk);
      #1 check("t6_prot_hit", prot_hit, 1);
      check("t6_no_push", {wr_pending, fifo_level}, 0);
      wr(15'h3FFF, 8'h44, 1);
      wait_drain();
      pulse_clr();
      check("t6_prot_cleared", prot_hit, 0);
`else
      wr(15'h4000, 8'h33, 1);
      wait_drain();
`endif
      check("final_queue", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
